// File: rtl/display_scan_controller.sv
// Four-digit common-anode 7-segment scan controller with per-digit blink,
// invalid-BCD blanking, and anti-ghosting dead time between digit slots.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank digit 3 when it is 0).
module display_scan_controller #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  blink_mask,
    input  logic        colon_on,
    output logic [3:0]  digit_code,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int unsigned RCNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BCNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_DIV - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_DIV - 1);
    localparam logic [1:0]        COLON_IDX = 2'd2;

    logic [RCNT_W-1:0] rcnt;
    logic [BCNT_W-1:0] bcnt;
    logic [1:0]        idx;
    logic              blink_phase;

    logic              rwrap_c;
    logic              bwrap_c;
    logic [3:0]        sel_c;
    logic              hidden_c;
    logic              invalid_c;
    logic              zero_blank_c;
    logic              blank_c;
    logic [3:0]        an_c;
    logic              dp_c;

    assign rwrap_c = (rcnt == RCNT_LAST);
    assign bwrap_c = (bcnt == BCNT_LAST);

    // Refresh/slot timing and blink phase generation
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt        <= '0;
            idx         <= 2'd0;
            bcnt        <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (rwrap_c) begin
                rcnt <= '0;
                idx  <= idx + 2'd1;
            end else begin
                rcnt <= rcnt + RCNT_W'(1);
            end
            if (bwrap_c) begin
                bcnt        <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                bcnt <= bcnt + BCNT_W'(1);
            end
        end
    end

    // Select the active digit and decide whether it is blanked this cycle
    always_comb begin
        sel_c = 4'h0;
        case (idx)
            2'd0:    sel_c = digits[3:0];
            2'd1:    sel_c = digits[7:4];
            2'd2:    sel_c = digits[11:8];
            default: sel_c = digits[15:12];
        endcase
        hidden_c     = blink_mask[idx] & blink_phase;
        invalid_c    = (sel_c > 4'd9);
        zero_blank_c = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        zero_blank_c = (idx == 2'd3) && (sel_c == 4'h0);
`endif
        blank_c = invalid_c | hidden_c | zero_blank_c | rwrap_c;
        an_c    = blank_c ? 4'hF : ~(4'b0001 << idx);
        // Colon follows blink and dead time only; an invalid digit 2 keeps it
        dp_c    = ~((idx == COLON_IDX) & colon_on & ~hidden_c & ~rwrap_c);
    end

    // Registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_code <= 4'h0;
            an         <= 4'hF;
            dp         <= 1'b1;
        end else begin
            digit_code <= sel_c;
            an         <= an_c;
            dp         <= dp_c;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized self-checking bench for display_scan_controller; expected outputs
// come from cycle-count arithmetic on the scan/blink rules.
module tb_display_scan_controller;

    localparam int R = 4;
    localparam int B = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = 16'h1234;
    logic [3:0]  blink_mask = 4'h0;
    logic        colon_on = 1'b0;
    logic [3:0]  digit_code;
    logic [3:0]  an;
    logic        dp;

    int n_cmp = 0;
    int n_err = 0;
    int n = 0;

    display_scan_controller #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .blink_mask (blink_mask),
        .colon_on   (colon_on),
        .digit_code (digit_code),
        .an         (an),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at load %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    // Expected outputs for the k-th register load after reset release
    function automatic void model(input int k, output logic [3:0] c,
                                  output logic [3:0] a, output logic d);
        int  id, slot, ph, val;
        bit  dead, hid, blank;
        slot  = k % R;
        id    = (k / R) % 4;
        ph    = (k / B) % 2;
        val   = (int'(digits) >> (4 * id)) & 15;
        dead  = (slot == R - 1);
        hid   = blink_mask[id] && (ph == 1);
        blank = (val > 9) || hid || dead;
`ifdef LEADING_ZERO_BLANK_EN
        if (id == 3 && val == 0) blank = 1'b1;
`endif
        c = 4'(val);
        a = blank ? 4'hF : 4'(15 & ~(1 << id));
        d = (id == 2 && colon_on && !hid && !dead) ? 1'b0 : 1'b1;
    endfunction

    task automatic step(input logic r);
        logic [3:0] ec, ea;
        logic       ed;
        rst = r;
        if (r) begin
            ec = 4'h0; ea = 4'hF; ed = 1'b1;
            n = 0;
        end else begin
            model(n, ec, ea, ed);
            n++;
        end
        @(posedge clk);
        #1;
        check(r ? "rst_code" : "digit_code", 32'(digit_code), 32'(ec));
        check(r ? "rst_an" : "an", 32'(an), 32'(ea));
        check(r ? "rst_dp" : "dp", 32'(dp), 32'(ed));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0);
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 11));
        if ($urandom_range(0, 3) == 0) v[15:12] = 4'h0;
        return v;
    endfunction

    initial begin
        // Reset held, then basic scan of 1234
        for (int i = 0; i < 3; i++) step(1'b1);
        run(40);
        colon_on = 1'b1;
        run(32);
        blink_mask = 4'b0011;
        run(64);
        blink_mask = 4'b0100;
        run(64);
        blink_mask = 4'b0000;
        digits = 16'h12A4;
        run(32);
        digits = 16'h0905;
        run(32);
        // Mid-slot reset, then a full slot afterwards
        run(6);
        step(1'b1);
        run(20);

        // Random phase: inputs change at arbitrary cycles, occasional resets
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0) digits = rand_digits();
            if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) colon_on = 1'($urandom);
            step($urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexed scan controller for the clock's four-digit common-anode 7-segment display. It cycles one digit at a time and selects that digit's BCD value for the shared `decoder_7segment` instance. It also drives the active-low anode enables and the colon decimal point. It applies per-digit blinking for time-set mode and blanks digits whose BCD value is invalid.

## Interface
- `REFRESH_DIV`, 100000: clock cycles each digit stays selected; must be ≥ 2.
- `BLINK_DIV`, 25000000: clock cycles per blink phase (half blink period); must be ≥ 1.

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `digits`  in  16  BCD digits; `[3:0]` = digit 0 (minutes units, rightmost) … `[15:12]` = digit 3 (hours tens)
- `blink_mask`  in  4  bit i = 1 makes digit i blink
- `colon_on`  in  1  1 = colon lit (shown as dp of digit 2)
- `digit_code`  out  4  BCD value to the `decoder_7segment` input
- `an`  out  4  anode enables, active low; `an[i]` is digit i
- `dp`  out  1  decimal point, active low

## Operation
- Refresh counter `rcnt` runs 0..REFRESH_DIV-1, then wraps.
- At wrap, the digit index `idx` advances 0→1→2→3→0 (2-bit wrap).
- Blink counter runs 0..BLINK_DIV-1. At its wrap, `blink_phase` toggles; 0 = visible, 1 = hidden.
- Per cycle, the registered outputs load from the current `idx`:
  - `digit_code` ← `digits[4*idx+3 : 4*idx]`.
  - `an` ← all ones except bit `idx` = 0, unless the digit is blanked. A blanked digit gives `an` = 4'b1111.
  - `dp` ← 0 only when `idx`==2, `colon_on`=1, and the digit is not hidden by blink; otherwise 1.
- A digit is blanked when any of these holds:
  - its value > 9 (the decoder has no defined pattern for it);
  - `blink_mask[idx]`=1 and `blink_phase`=1;
  - it is in the dead-time cycle.
- Dead time (anti-ghosting): when `rcnt`==REFRESH_DIV-1, `an` is forced to 4'b1111 and `dp` to 1.
- `digit_code` still carries the value of a blanked digit; only `an` and `dp` blank.
- Inputs are not latched. A change to `digits`, `blink_mask` or `colon_on` takes effect on the next register load, mid-slot if needed.

## Timing
- Reset values: `an`=4'b1111, `dp`=1, `digit_code`=4'h0, `idx`=0, `rcnt`=0, blink counter=0, `blink_phase`=0.
- First clock edge after `rst` falls loads `an`=4'b1110 and `digit_code`=`digits[3:0]` (when digit 0 is valid and visible).
- Latency from an input change to the outputs: 1 cycle.
- Each digit slot is REFRESH_DIV cycles: REFRESH_DIV-1 lit cycles plus 1 dead cycle.
- Full scan is 4×REFRESH_DIV cycles.
- `rst` asserted mid-scan returns every output to its reset value on that same edge. The counters restart, so the first slot after release is a full slot.
- When the blink wrap and the refresh wrap fall on the same edge, both take effect on that edge independently.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: digit 3 is also blanked when `digits[15:12]`==0. This shows "9:05" instead of "09:05". The blanking applies only to digit 3; digits 0–2 are never zero-blanked.
- `LEADING_ZERO_BLANK_EN` undefined: digit 3 shows 0 normally. No related logic is synthesized.

## Test plan
All scenarios use REFRESH_DIV=4 and BLINK_DIV=16.

- **Reset:** hold `rst` 3 cycles → `an`=1111, `dp`=1, `digit_code`=0 throughout. First edge after release: `an`=1110, `digit_code`=`digits[3:0]`.
- **Scan order:** `digits`=16'h1234, no blink → `an`/`digit_code` sequence is 1110/4 (3 cycles), 1111 (1 cycle), 1101/3, 1111, 1011/2, 1111, 0111/1, 1111, then repeats.
- **Colon:** `colon_on`=1 → `dp`=0 only during the lit cycles of digit 2 (`an`=1011); `dp`=1 in every other cycle, including the dead cycle.
- **Blink:** `blink_mask`=4'b0011 → digits 0 and 1 are lit for 16 cycles and dark for the next 16 (`an`=1111 in their slots); digits 2 and 3 are unaffected. With `colon_on`=1 and `blink_mask[2]`=1, `dp` stays 1 in the hidden phase.
- **Invalid BCD:** `digits[7:4]`=4'hA → `an`=1111 throughout digit 1's slot while `digit_code`=A; the other digits display normally.
- **Leading zero:** `digits`=16'h0905. With the macro, digit 3's slot shows `an`=1111. Without the macro, digit 3's slot shows `an`=0111, `digit_code`=0. A reset asserted mid-slot returns all outputs to reset values on the same edge.
